// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        LOAD_LEN,
        LOAD_DATA,
        DONE,
        RUN,
        ERROR
    } loader_state_type;

    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/program_loader_if.sv
// Loader-side bundle: UART byte strobe in, program-memory port and core-control out.
interface program_loader_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [31:0] pc_address;
    logic [31:0] mem_byte_address;
    logic        mem_write_enable;
    logic [31:0] mem_write_data;
    logic        cpu_reset_n;
    logic        loading;
    logic        load_error;
    logic [31:0] words_loaded;

    modport master (
        input  rx_data, rx_valid, pc_address,
        output mem_byte_address, mem_write_enable, mem_write_data,
        output cpu_reset_n, loading, load_error, words_loaded
    );

    modport slave (
        output rx_data, rx_valid, pc_address,
        input  mem_byte_address, mem_write_enable, mem_write_data,
        input  cpu_reset_n, loading, load_error, words_loaded
    );

endinterface

// File: rtl/program_loader_byte_assembler.sv
// Packs a byte stream into little-endian 32-bit words; word/word_valid are combinational
// in the cycle the 4th byte arrives. No backpressure: every in_valid byte is taken.
module byte_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic [31:0] word,
    output logic        word_valid,
    output logic [1:0]  byte_index
);

    logic [1:0]  idx_q, idx_d;
    logic [31:0] shift_q, shift_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q   <= 2'd0;
            shift_q <= 32'd0;
        end else begin
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // New bytes enter at the top so the first byte ends up in bits [7:0].
    always_comb begin
        idx_d      = idx_q;
        shift_d    = shift_q;
        word       = {in_data, shift_q[31:8]};
        word_valid = 1'b0;
        if (clear) begin
            idx_d   = 2'd0;
            shift_d = 32'd0;
        end else if (in_valid) begin
            shift_d    = word;
            idx_d      = idx_q + 2'd1;
            word_valid = (idx_q == 2'(BYTES_PER_WORD - 1));
        end
    end

    assign byte_index = idx_q;

endmodule

// File: rtl/program_loader.sv
// Boot loader: writes a UART-delivered image into program memory, then releases the core.
// Write pulse one cycle after a word's last byte; no backpressure, bytes may arrive every cycle.
module program_loader
    import loader_pkg::*;
#(
    parameter int          MEM_WORDS      = 1024,
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter int          TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    program_loader_if.master  bus
);

    loader_state_type state_q, state_d;
    logic [31:0] n_q, n_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] words_q, words_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic        cpu_rst_n_q, cpu_rst_n_d;
    logic        err_q, err_d;
    logic [31:0] tmo_q, tmo_d;

    logic        receiving;
    logic        asm_valid;
    logic [31:0] asm_word;
    logic        asm_word_valid;
    logic [1:0]  asm_index;
    logic        timeout_hit;

    assign receiving   = (state_q == LOAD_LEN) || (state_q == LOAD_DATA);
    assign asm_valid   = bus.rx_valid && receiving;
    assign timeout_hit = receiving && !bus.rx_valid && (tmo_q == 32'(TIMEOUT_CYCLES - 1));

    byte_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (state_q == ERROR),
        .in_valid   (asm_valid),
        .in_data    (bus.rx_data),
        .word       (asm_word),
        .word_valid (asm_word_valid),
        .byte_index (asm_index)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= LOAD_LEN;
            n_q         <= 32'd0;
            addr_q      <= BASE_ADDR;
            words_q     <= 32'd0;
            we_q        <= 1'b0;
            wdata_q     <= 32'd0;
            cpu_rst_n_q <= 1'b0;
            err_q       <= 1'b0;
            tmo_q       <= 32'd0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            addr_q      <= addr_d;
            words_q     <= words_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        addr_d  = addr_q;
        words_d = words_q;
        we_d    = 1'b0;
        wdata_d = wdata_q;
        tmo_d   = (!receiving || bus.rx_valid) ? 32'd0 : tmo_q + 32'd1;

        case (state_q)
            LOAD_LEN: begin
                if (asm_word_valid) begin
                    n_d = asm_word;
                    if (asm_word == 32'd0) begin
                        state_d = RUN;
                    end else if (asm_word > 32'(MEM_WORDS)) begin
                        state_d = ERROR;
                    end else begin
                        state_d = LOAD_DATA;
                        addr_d  = BASE_ADDR;
                        words_d = 32'd0;
                    end
                end else if (timeout_hit) begin
                    // An idle line with nothing started boots whatever is already in memory.
                    state_d = (asm_index == 2'd0) ? RUN : ERROR;
                end
            end
            LOAD_DATA: begin
                if (timeout_hit) begin
                    state_d = ERROR;
                end
                if (asm_word_valid) begin
                    we_d    = 1'b1;
                    wdata_d = asm_word;
                end
                if (we_q) begin
                    addr_d  = addr_q + 32'd4;
                    words_d = words_q + 32'd1;
                    if (words_q + 32'd1 == n_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = RUN;
            RUN:     state_d = RUN;
            ERROR:   state_d = LOAD_LEN;
            default: state_d = LOAD_LEN;
        endcase

        err_d       = err_q || (state_d == ERROR);
        cpu_rst_n_d = (state_d == RUN);
    end

    assign bus.mem_byte_address = (state_q == RUN) ? bus.pc_address : addr_q;
    assign bus.mem_write_enable = we_q;
    assign bus.mem_write_data   = wdata_q;
    assign bus.cpu_reset_n      = cpu_rst_n_q;
    assign bus.loading          = (state_q != RUN);
    assign bus.load_error       = err_q;
    assign bus.words_loaded     = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a small memory and short timeout.
module tb_program_loader;
    import loader_pkg::*;

    localparam int MEM_WORDS = 8;
    localparam int TIMEOUT   = 16;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   wr_count;

    program_loader_if bus_if ();

    program_loader #(
        .MEM_WORDS      (MEM_WORDS),
        .BASE_ADDR      (32'h0),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset) wr_count <= 0;
        else if (bus_if.mem_write_enable) wr_count <= wr_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus_if.rx_data  = b;
        bus_if.rx_valid = 1'b1;
        tick();
        bus_if.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] tmp;
            tmp = w >> (8 * i);
            send_byte(tmp[7:0]);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus_if.rx_data    = 8'h00;
        bus_if.rx_valid   = 1'b0;
        bus_if.pc_address = 32'h0000_1234;

        // Reset values
        do_reset();
        check("rst_loading", {31'd0, bus_if.loading}, 32'd1);
        check("rst_cpu_reset_n", {31'd0, bus_if.cpu_reset_n}, 32'd0);
        check("rst_we", {31'd0, bus_if.mem_write_enable}, 32'd0);
        check("rst_wdata", bus_if.mem_write_data, 32'd0);
        check("rst_error", {31'd0, bus_if.load_error}, 32'd0);
        check("rst_words", bus_if.words_loaded, 32'd0);
        check("rst_addr", bus_if.mem_byte_address, 32'h0);
        check("rst_state", 32'(dut.state_q), 32'(LOAD_LEN));

        // Two-word image, one byte per cycle
        send_word(32'd2);
        check("t1_state_data", 32'(dut.state_q), 32'(LOAD_DATA));
        send_word(32'h0000_0013);
        check("t1_w0_we", {31'd0, bus_if.mem_write_enable}, 32'd1);
        check("t1_w0_data", bus_if.mem_write_data, 32'h0000_0013);
        check("t1_w0_addr", bus_if.mem_byte_address, 32'h0);
        send_byte(8'h93);
        check("t1_pulse_one_cycle", {31'd0, bus_if.mem_write_enable}, 32'd0);
        check("t1_addr_adv", bus_if.mem_byte_address, 32'h4);
        check("t1_words_1", bus_if.words_loaded, 32'd1);
        send_byte(8'h00);
        send_byte(8'hA0);
        send_byte(8'h00);
        check("t1_w1_we", {31'd0, bus_if.mem_write_enable}, 32'd1);
        check("t1_w1_data", bus_if.mem_write_data, 32'h00A0_0093);
        check("t1_w1_addr", bus_if.mem_byte_address, 32'h4);
        tick();
        check("t1_words_2", bus_if.words_loaded, 32'd2);
        check("t1_done_state", 32'(dut.state_q), 32'(DONE));
        check("t1_done_cpu_rst", {31'd0, bus_if.cpu_reset_n}, 32'd0);
        check("t1_done_no_we", {31'd0, bus_if.mem_write_enable}, 32'd0);
        tick();
        check("t1_run_cpu_rst", {31'd0, bus_if.cpu_reset_n}, 32'd1);
        check("t1_run_loading", {31'd0, bus_if.loading}, 32'd0);
        check("t1_pc_pass", bus_if.mem_byte_address, 32'h0000_1234);
        bus_if.pc_address = 32'h0000_0040;
        #1;
        check("t1_pc_comb", bus_if.mem_byte_address, 32'h0000_0040);
        send_word(32'hFFFF_FFFF);
        tick();
        check("t1_run_ignores_rx", bus_if.words_loaded, 32'd2);
        check("t1_write_count", wr_count, 32'd2);

        // Boot timeout with no bytes
        do_reset();
        repeat (TIMEOUT - 1) tick();
        check("t2_still_loading", {31'd0, bus_if.loading}, 32'd1);
        tick();
        check("t2_run_at_16", {31'd0, bus_if.loading}, 32'd0);
        check("t2_cpu_rst", {31'd0, bus_if.cpu_reset_n}, 32'd1);
        check("t2_no_error", {31'd0, bus_if.load_error}, 32'd0);
        check("t2_no_writes", wr_count, 32'd0);

        // Empty image
        do_reset();
        send_word(32'd0);
        check("t3_run", 32'(dut.state_q), 32'(RUN));
        check("t3_cpu_rst", {31'd0, bus_if.cpu_reset_n}, 32'd1);
        tick();
        check("t3_no_writes", wr_count, 32'd0);

        // Largest legal length is accepted
        do_reset();
        send_word(32'(MEM_WORDS));
        check("t4_max_ok", 32'(dut.state_q), 32'(LOAD_DATA));

        // Oversize length, then a good image
        do_reset();
        send_word(32'(MEM_WORDS + 1));
        check("t4_error_state", 32'(dut.state_q), 32'(ERROR));
        check("t4_error_flag", {31'd0, bus_if.load_error}, 32'd1);
        check("t4_cpu_rst_low", {31'd0, bus_if.cpu_reset_n}, 32'd0);
        tick();
        check("t4_back_len", 32'(dut.state_q), 32'(LOAD_LEN));
        send_word(32'd1);
        send_word(32'hDEAD_BEEF);
        check("t4_we", {31'd0, bus_if.mem_write_enable}, 32'd1);
        check("t4_data", bus_if.mem_write_data, 32'hDEAD_BEEF);
        check("t4_addr", bus_if.mem_byte_address, 32'h0);
        tick();
        tick();
        check("t4_run", {31'd0, bus_if.cpu_reset_n}, 32'd1);
        check("t4_error_sticky", {31'd0, bus_if.load_error}, 32'd1);

        // Stall mid-transfer
        do_reset();
        send_word(32'd3);
        send_word(32'h4433_2211);
        send_byte(8'h55);
        send_byte(8'h66);
        repeat (TIMEOUT - 1) tick();
        check("t5_no_error_yet", {31'd0, bus_if.load_error}, 32'd0);
        tick();
        check("t5_error", {31'd0, bus_if.load_error}, 32'd1);
        tick();
        check("t5_back_len", 32'(dut.state_q), 32'(LOAD_LEN));
        check("t5_cpu_rst_low", {31'd0, bus_if.cpu_reset_n}, 32'd0);
        check("t5_one_write", wr_count, 32'd1);

        // Reset in the middle of a load
        do_reset();
        send_word(32'd2);
        send_byte(8'hAA);
        do_reset();
        check("t6_loading", {31'd0, bus_if.loading}, 32'd1);
        check("t6_words", bus_if.words_loaded, 32'd0);
        check("t6_error", {31'd0, bus_if.load_error}, 32'd0);
        check("t6_state", 32'(dut.state_q), 32'(LOAD_LEN));
        send_word(32'd1);
        send_word(32'h0000_0013);
        check("t6_we", {31'd0, bus_if.mem_write_enable}, 32'd1);
        check("t6_data", bus_if.mem_write_data, 32'h0000_0013);
        check("t6_addr", bus_if.mem_byte_address, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
